// File: rtl/demux_scatter_if.sv
// demux_scatter_if: handshake and frame bus between an upstream word source,
// the demux_scatter block and a downstream frame consumer.
//   slave  : the scatter block (accepts words, presents the frame)
//   master : the environment driving words and acknowledging frames
// Signals: clear, in_valid/in_ready, auto_mode, sel, IN (word in),
//          OUT, slot_valid, out_valid/out_ack (frame out), err (range error).
interface demux_scatter_if #(
  parameter int BIT           = 27,
  parameter int NUMBER_OUTPUT = 512,
  parameter int SW            = $clog2(NUMBER_OUTPUT)
);
  logic                          clear;
  logic                          in_valid;
  logic                          in_ready;
  logic                          auto_mode;
  logic [SW-1:0]                 sel;
  logic [BIT-1:0]                IN;
  logic [NUMBER_OUTPUT*BIT-1:0]  OUT;
  logic [NUMBER_OUTPUT-1:0]      slot_valid;
  logic                          out_valid;
  logic                          out_ack;
  logic                          err;

  modport slave (
    input  clear, in_valid, auto_mode, sel, IN, out_ack,
    output in_ready, OUT, slot_valid, out_valid, err
  );

  modport master (
    output clear, in_valid, auto_mode, sel, IN, out_ack,
    input  in_ready, OUT, slot_valid, out_valid, err
  );
endinterface

// File: rtl/demux_scatter.sv
// demux_scatter: accepts one BIT-wide word per handshake and scatters it
// into one of NUMBER_OUTPUT slots of a registered wide bus. Once every slot
// of the frame is valid the frame is offered downstream with out_valid and
// held until out_ack.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    demux_scatter_if.slave (word handshake, slot select, frame bus)
//
// state | meaning
// FILL  | accepting words, frame incomplete
// FULL  | all slots valid, frame offered downstream, inputs stalled
module demux_scatter #(
  parameter  int BIT           = 27,
  parameter  int NUMBER_OUTPUT = 512,
  localparam int SW            = $clog2(NUMBER_OUTPUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  demux_scatter_if.slave   bus
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t                        state_q, state_d;
  logic [NUMBER_OUTPUT*BIT-1:0]  out_q;
  logic [NUMBER_OUTPUT-1:0]      slot_valid_q, slot_valid_d;
  logic [SW-1:0]                 ptr_q, ptr_d;
  logic                          err_q, err_d;

  logic [SW-1:0]                 idx;
  logic                          wr;
  logic                          in_range;
  logic                          wr_ok;

  assign idx      = bus.auto_mode ? ptr_q : bus.sel;
  // Only reachable as false when NUMBER_OUTPUT is not a power of two.
  assign in_range = {{(32-SW){1'b0}}, idx} < 32'(NUMBER_OUTPUT);
  // A write coincident with clear is dropped.
  assign wr       = bus.in_valid && (state_q == FILL) && !bus.clear;
  assign wr_ok    = wr && in_range;

  always_comb begin
    state_d      = state_q;
    slot_valid_d = slot_valid_q;
    ptr_d        = ptr_q;
    err_d        = 1'b0;

    if (bus.clear) begin
      state_d      = FILL;
      slot_valid_d = '0;
      ptr_d        = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (wr) begin
            if (wr_ok) slot_valid_d[idx] = 1'b1;
            else       err_d             = 1'b1;
            if (bus.auto_mode)
              ptr_d = (ptr_q == SW'(NUMBER_OUTPUT-1)) ? '0 : ptr_q + 1'b1;
            if (wr_ok && (&slot_valid_d)) state_d = FULL;
          end
        end
        FULL: begin
          if (bus.out_ack) begin
            state_d      = FILL;
            slot_valid_d = '0;
            ptr_d        = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FILL;
      out_q        <= '0;
      slot_valid_q <= '0;
      ptr_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_valid_q <= slot_valid_d;
      ptr_q        <= ptr_d;
      err_q        <= err_d;
      // Frame data survives clear and out_ack; only reset zeroes it.
      if (wr_ok) out_q[int'(idx)*BIT +: BIT] <= bus.IN;
    end
  end

  assign bus.OUT        = out_q;
  assign bus.slot_valid = slot_valid_q;
  assign bus.err        = err_q;
  assign bus.in_ready   = (state_q == FILL);
  assign bus.out_valid  = (state_q == FULL);

endmodule

// File: tb/tb_demux_scatter.sv
// tb_demux_scatter: directed test of demux_scatter with two instances,
// NUMBER_OUTPUT=4 (power of two) and NUMBER_OUTPUT=3 (out-of-range index
// possible), both with BIT=8.
module tb_demux_scatter;

  logic clk;
  logic rst_n_a;
  logic rst_n_b;
  int   total;
  int   bad;

  demux_scatter_if #(.BIT(8), .NUMBER_OUTPUT(4)) ifa ();
  demux_scatter_if #(.BIT(8), .NUMBER_OUTPUT(3)) ifb ();

  demux_scatter #(.BIT(8), .NUMBER_OUTPUT(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (ifa)
  );

  demux_scatter #(.BIT(8), .NUMBER_OUTPUT(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    ifa.clear = 0; ifa.in_valid = 0; ifa.auto_mode = 0; ifa.sel = '0; ifa.IN = '0; ifa.out_ack = 0;
    ifb.clear = 0; ifb.in_valid = 0; ifb.auto_mode = 0; ifb.sel = '0; ifb.IN = '0; ifb.out_ack = 0;
    tick();
    check_val("a_rst_out",   64'(ifa.OUT),        64'h0);
    check_val("a_rst_sv",    64'(ifa.slot_valid), 64'h0);
    check_val("a_rst_ready", 64'(ifa.in_ready),   64'h1);
    check_val("a_rst_ovld",  64'(ifa.out_valid),  64'h0);
    check_val("a_rst_err",   64'(ifa.err),        64'h0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // Auto-mode fill of four slots back to back.
    ifa.auto_mode = 1; ifa.in_valid = 1;
    ifa.IN = 8'h11; tick();
    ifa.IN = 8'h22; tick();
    ifa.IN = 8'h33; tick();
    check_val("a_fill3_ovld", 64'(ifa.out_valid),  64'h0);
    check_val("a_fill3_sv",   64'(ifa.slot_valid), 64'h7);
    ifa.IN = 8'h44; tick();
    check_val("a_full_out",   64'(ifa.OUT),        64'h44332211);
    check_val("a_full_sv",    64'(ifa.slot_valid), 64'hF);
    check_val("a_full_ovld",  64'(ifa.out_valid),  64'h1);
    check_val("a_full_ready", 64'(ifa.in_ready),   64'h0);

    // Held word while FULL is ignored; then ack.
    ifa.IN = 8'h55; tick();
    check_val("a_hold_out", 64'(ifa.OUT),        64'h44332211);
    check_val("a_hold_sv",  64'(ifa.slot_valid), 64'hF);
    ifa.out_ack = 1; tick();
    ifa.out_ack = 0;
    check_val("a_ack_sv",    64'(ifa.slot_valid), 64'h0);
    check_val("a_ack_ready", 64'(ifa.in_ready),   64'h1);
    check_val("a_ack_out",   64'(ifa.OUT),        64'h44332211);
    tick();
    ifa.in_valid = 0;
    check_val("a_re_out", 64'(ifa.OUT),        64'h44332255);
    check_val("a_re_sv",  64'(ifa.slot_valid), 64'h1);

    // Explicit mode in a fresh frame, with overwrite of slot 2.
    ifa.clear = 1; tick();
    ifa.clear = 0;
    check_val("a_clr_sv", 64'(ifa.slot_valid), 64'h0);
    ifa.auto_mode = 0; ifa.in_valid = 1;
    ifa.sel = 2'd2; ifa.IN = 8'hAA; tick();
    check_val("a_x1_err", 64'(ifa.err), 64'h0);
    ifa.sel = 2'd2; ifa.IN = 8'hBB; tick();
    check_val("a_x2_err", 64'(ifa.err), 64'h0);
    ifa.sel = 2'd0; ifa.IN = 8'hCC; tick();
    ifa.in_valid = 0;
    check_val("a_x3_err",  64'(ifa.err),        64'h0);
    check_val("a_x_out",   64'(ifa.OUT),        64'h44BB22CC);
    check_val("a_x_sv",    64'(ifa.slot_valid), 64'h5);
    check_val("a_x_ovld",  64'(ifa.out_valid),  64'h0);

    // Clear coincident with a write drops the word and rewinds the pointer.
    ifa.clear = 1; tick();
    ifa.clear = 0;
    ifa.auto_mode = 1; ifa.in_valid = 1;
    ifa.IN = 8'h01; tick();
    ifa.IN = 8'h02; tick();
    ifa.clear = 1; ifa.IN = 8'h99; tick();
    ifa.clear = 0;
    check_val("a_cw_sv",  64'(ifa.slot_valid), 64'h0);
    check_val("a_cw_out", 64'(ifa.OUT),        64'h44BB0201);
    ifa.IN = 8'h66; tick();
    check_val("a_cw2_out", 64'(ifa.OUT),        64'h44BB0266);
    check_val("a_cw2_sv",  64'(ifa.slot_valid), 64'h1);

    // Two more auto writes (three total), then a reset glitch between edges.
    ifa.IN = 8'h07; tick();
    ifa.IN = 8'h08; tick();
    ifa.in_valid = 0;
    rst_n_a = 1'b0; #2; rst_n_a = 1'b1;
    tick();
    check_val("a_glitch_sv",  64'(ifa.slot_valid), 64'h7);
    check_val("a_glitch_out", 64'(ifa.OUT),        64'h44080766);
    rst_n_a = 1'b0; tick();
    rst_n_a = 1'b1;
    check_val("a_mrst_out",   64'(ifa.OUT),        64'h0);
    check_val("a_mrst_sv",    64'(ifa.slot_valid), 64'h0);
    check_val("a_mrst_ovld",  64'(ifa.out_valid),  64'h0);
    check_val("a_mrst_ready", 64'(ifa.in_ready),   64'h1);
    ifa.in_valid = 1; ifa.IN = 8'h5A; tick();
    ifa.in_valid = 0;
    check_val("a_post_out", 64'(ifa.OUT),        64'h5A);
    check_val("a_post_sv",  64'(ifa.slot_valid), 64'h1);

    // NUMBER_OUTPUT=3: out-of-range index then full explicit fill.
    ifb.auto_mode = 0; ifb.in_valid = 1;
    ifb.sel = 2'd3; ifb.IN = 8'h77; tick();
    ifb.in_valid = 0;
    check_val("b_oor_out", 64'(ifb.OUT),        64'h0);
    check_val("b_oor_sv",  64'(ifb.slot_valid), 64'h0);
    check_val("b_oor_err", 64'(ifb.err),        64'h1);
    tick();
    check_val("b_oor_err_off", 64'(ifb.err), 64'h0);
    ifb.in_valid = 1;
    ifb.sel = 2'd0; ifb.IN = 8'h10; tick();
    ifb.sel = 2'd1; ifb.IN = 8'h20; tick();
    check_val("b_part_ovld", 64'(ifb.out_valid), 64'h0);
    ifb.sel = 2'd2; ifb.IN = 8'h30; tick();
    ifb.in_valid = 0;
    check_val("b_full_ovld", 64'(ifb.out_valid),  64'h1);
    check_val("b_full_out",  64'(ifb.OUT),        64'h302010);
    check_val("b_full_sv",   64'(ifb.slot_valid), 64'h7);
    check_val("b_full_err",  64'(ifb.err),        64'h0);
    // Explicit writes held the pointer at 0: next auto write lands in slot 0.
    ifb.out_ack = 1; tick();
    ifb.out_ack = 0;
    ifb.auto_mode = 1; ifb.in_valid = 1; ifb.IN = 8'h40; tick();
    ifb.in_valid = 0;
    check_val("b_auto_out", 64'(ifb.OUT),        64'h302040);
    check_val("b_auto_sv",  64'(ifb.slot_valid), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_scatter.md
Name: demux_scatter

Overview:
- Inverse of the codebase's wide N:1 select block: accepts one BIT-wide word per handshake and scatters it into one of NUMBER_OUTPUT slots of a registered wide bus.
- Slots are addressed by an explicit index or by an internal auto-increment pointer.
- Tracks per-slot valid bits and presents the full frame to downstream with a valid/ack handshake, so a later N:1 select stage can read a fully populated bus.

Parameters:
- BIT, 27, width of one data word.
- NUMBER_OUTPUT, 512, number of slots; need not be a power of two.
- SW, $clog2(NUMBER_OUTPUT), index width (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- clear  input  1  synchronous frame abort.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word.
- auto_mode  input  1  1 = use internal pointer, 0 = use sel.
- sel  input  SW  explicit slot index; used when auto_mode=0.
- IN  input  BIT  data word.
- OUT  output  NUMBER_OUTPUT*BIT  slot k occupies OUT[k*BIT +: BIT].
- slot_valid  output  NUMBER_OUTPUT  bit k = slot k written in the current frame.
- out_valid  output  1  frame complete (all slots valid).
- out_ack  input  1  downstream consumed the frame.
- err  output  1  one-cycle pulse on an out-of-range write.

Behaviour:
- Reset (rst_n=0 at the clock edge): OUT=0, slot_valid=0, ptr=0, err=0, state=FILL.
- Combinational outputs during reset: in_ready=1, out_valid=0.
- State FILL:
  - in_ready=1, out_valid=0.
  - A write occurs when in_valid && in_ready.
  - Target index is ptr when auto_mode=1, otherwise sel.
- State FULL:
  - in_ready=0, out_valid=1.
  - in_valid is ignored.
- Write (target idx < NUMBER_OUTPUT):
  - OUT slot idx <= IN and slot_valid[idx] <= 1 at the same edge.
  - Visible on OUT the cycle after the handshake (latency 1).
  - Rewriting an already-valid slot overwrites the data, with no error.
- Out-of-range (idx >= NUMBER_OUTPUT, only possible when NUMBER_OUTPUT is not a power of two):
  - Write dropped; OUT and slot_valid unchanged.
  - err=1 for exactly the next cycle.
  - ptr still advances.
- Pointer:
  - ptr advances only on an auto_mode=1 handshake.
  - ptr wraps from NUMBER_OUTPUT-1 to 0.
  - ptr is held during explicit-mode writes.
  - Mixing modes within a frame is legal.
- FILL->FULL: at the edge where the resulting slot_valid is all ones. out_valid=1 in the following cycle (one cycle after the final write).
- FULL->FILL: on out_ack=1. At that edge slot_valid <= 0 and ptr <= 0, and in_ready=1 the next cycle. OUT data is retained, not zeroed.
- out_ack in FILL is ignored.
- clear=1 (any state): slot_valid <= 0, ptr <= 0, state <= FILL, err <= 0. OUT is retained.
- Priority: rst_n > clear > write/out_ack. A write coincident with clear is dropped.
- FULL with out_ack and in_valid in the same cycle: no write in that cycle (in_ready=0); the word must be re-presented.
- Reset mid-frame: all partial slot_valid bits are lost, OUT is zeroed, and the first post-reset write targets ptr=0.
- No combinational path from IN or sel to OUT. in_ready and out_valid are decoded from the state register only.

Test Plan:
- BIT=8, NUMBER_OUTPUT=4, auto_mode=1, write 0x11,0x22,0x33,0x44 back-to-back -> OUT=0x44332211, slot_valid=4'b1111, out_valid=1 one cycle after the 4th write, in_ready=0.
- From FULL, hold in_valid=1 with 0x55, then pulse out_ack -> no write while FULL; slot_valid=0, in_ready=1 next cycle, OUT still 0x44332211; 0x55 then lands in slot 0.
- Explicit mode: sel=2 write 0xAA, sel=2 write 0xBB, sel=0 write 0xCC -> OUT slot2=0xBB, slot0=0xCC, slot_valid=4'b0101, out_valid=0, err never set.
- NUMBER_OUTPUT=3 (SW=2), auto_mode=0, sel=3 write 0x77 -> OUT/slot_valid unchanged, err=1 for exactly one cycle; then sel=0,1,2 writes -> out_valid=1.
- After 2 auto writes, assert clear together with in_valid (0x99) -> 0x99 dropped, slot_valid=0, ptr=0; next auto write lands in slot 0.
- After 3 auto writes, drive rst_n=0 for one edge -> OUT=0, slot_valid=0, out_valid=0, in_ready=1; asynchronous rst_n glitch between edges has no effect.
